ip_tx_header_arbiter: RTL and testbench

- Shares one IP transmit path (IP header handshake plus byte-stream payload) between N FPGA-side requesters.
- Each requester presents a full IP/Ethernet header and a payload stream. Requesters are granted round-robin.
- A grant is held from header acceptance until the payload beat carrying tlast has been transferred.
- Sits between user packet generators (UDP/ICMP engines) and the IP TX framer.

---
 rtl/ip_tx_header_arbiter_pkg.sv | 40 ++++
 rtl/ip_tx_header_arbiter_rr_pick.sv | 32 +++
 rtl/ip_tx_header_arbiter.sv | 173 +++++++++++++++++
 tb/tb_ip_tx_header_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_tx_header_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module      : ip_tx_pkg
// Description : Shared types for the IP TX header arbiter (header struct, FSM states).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ip_tx_pkg;

    localparam int IP_HDR_W = 272;

    typedef struct packed {
        logic [47:0] eth_dest_mac;
        logic [47:0] eth_src_mac;
        logic [15:0] eth_type;
        logic [3:0]  version;
        logic [3:0]  ihl;
        logic [5:0]  dscp;
        logic [1:0]  ecn;
        logic [15:0] length;
        logic [15:0] identification;
        logic [2:0]  flags;
        logic [12:0] fragment_offset;
        logic [7:0]  ttl;
        logic [7:0]  protocol;
        logic [15:0] header_checksum;
        logic [31:0] source_ip;
        logic [31:0] dest_ip;
    } ip_hdr_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2,
        DRAIN   = 2'd3
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/ip_tx_header_arbiter_rr_pick.sv
//------------------------------------------------------------------------------
// Module      : rr_pick
// Description : Combinational round-robin picker; searches from last+1 with wrap.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
    parameter int N_SRC = 4,
    parameter int IDX_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    assign valid = |req;

    // Walk from the farthest candidate to the nearest so the nearest set bit wins.
    always_comb begin
        idx = '0;
        for (int i = N_SRC; i >= 1; i--) begin
            if (req[(int'(last) + i) % N_SRC]) begin
                idx = IDX_W'((int'(last) + i) % N_SRC);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ip_tx_header_arbiter.sv
//------------------------------------------------------------------------------
// Module      : ip_tx_header_arbiter
// Description : Round-robin share of one IP TX header+payload path among N_SRC
//               requesters. Optional payload stall abort: IP_TX_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ip_tx_header_arbiter
    import ip_tx_pkg::*;
#(
    parameter int N_SRC          = 4,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IDX_W         = $clog2(N_SRC)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_SRC-1:0]               in_hdr_valid,
    output logic [N_SRC-1:0]               in_hdr_ready,
    input  ip_hdr_t [N_SRC-1:0]            in_hdr,
    input  logic [N_SRC-1:0][DATA_W-1:0]   in_tdata,
    input  logic [N_SRC-1:0]               in_tvalid,
    output logic [N_SRC-1:0]               in_tready,
    input  logic [N_SRC-1:0]               in_tlast,
    output logic                           out_hdr_valid,
    input  logic                           out_hdr_ready,
    output ip_hdr_t                        out_hdr,
    output logic [DATA_W-1:0]              out_tdata,
    output logic                           out_tvalid,
    input  logic                           out_tready,
    output logic                           out_tlast,
    output logic [IDX_W-1:0]               grant_id,
    output logic                           busy,
    output logic                           timeout_abort
);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    ip_hdr_t          r_out_hdr;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] r_last_grant;
    logic             w_pick_valid;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_hdr_take;
    logic             w_pkt_done;
    logic             w_beat;

    rr_pick #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (in_hdr_valid),
        .last  (r_last_grant),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

`ifdef IP_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_forced;

    assign w_forced = (r_stall_cnt == CNT_W'(TIMEOUT_CYCLES));

    // Counts only stalled PAYLOAD cycles; saturates so the forced beat holds.
    always_ff @(posedge clk) begin
        if (!rst_n || r_state != PAYLOAD) begin
            r_stall_cnt <= '0;
        end else if (w_beat) begin
            r_stall_cnt <= '0;
        end else if (!in_tvalid[r_grant] && !w_forced) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end
`else
    assign timeout_abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        in_hdr_ready = '0;
        in_tready    = '0;
        out_tdata    = '0;
        out_tvalid   = 1'b0;
        out_tlast    = 1'b0;
        w_hdr_take   = 1'b0;
        w_pkt_done   = 1'b0;
        w_beat       = 1'b0;
`ifdef IP_TX_ARB_TIMEOUT_EN
        timeout_abort = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    in_hdr_ready[w_pick_idx] = 1'b1;
                    w_hdr_take               = 1'b1;
                    w_state_nxt              = HDR;
                end
            end
            HDR: begin
                if (out_hdr_ready) begin
                    w_state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
`ifdef IP_TX_ARB_TIMEOUT_EN
                if (w_forced) begin
                    out_tvalid = 1'b1;
                    out_tlast  = 1'b1;
                    if (out_tready) begin
                        timeout_abort = 1'b1;
                        w_state_nxt   = DRAIN;
                    end
                end else
`endif
                begin
                    out_tdata            = in_tdata[r_grant];
                    out_tvalid           = in_tvalid[r_grant];
                    out_tlast            = in_tlast[r_grant];
                    in_tready[r_grant]   = out_tready;
                    w_beat               = in_tvalid[r_grant] && out_tready;
                    if (w_beat && in_tlast[r_grant]) begin
                        w_pkt_done  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
`ifdef IP_TX_ARB_TIMEOUT_EN
            DRAIN: begin
                in_tready[r_grant] = 1'b1;
                if (in_tvalid[r_grant] && in_tlast[r_grant]) begin
                    w_pkt_done  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_hdr    <= '0;
            r_grant      <= '0;
            r_last_grant <= IDX_W'(N_SRC - 1);
        end else begin
            if (w_hdr_take) begin
                r_out_hdr <= in_hdr[w_pick_idx];
                r_grant   <= w_pick_idx;
            end
            if (w_pkt_done) begin
                r_last_grant <= r_grant;
            end
        end
    end

    assign out_hdr       = r_out_hdr;
    assign out_hdr_valid = (r_state == HDR);
    assign grant_id      = r_grant;
    assign busy          = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ip_tx_header_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_ip_tx_header_arbiter
// Description : Directed self-checking bench for ip_tx_header_arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ip_tx_header_arbiter;
    import ip_tx_pkg::*;

    logic                 clk;
    logic                 rst_n;
    logic [3:0]           in_hdr_valid;
    logic [3:0]           in_hdr_ready;
    ip_hdr_t [3:0]        in_hdr;
    logic [3:0][7:0]      in_tdata;
    logic [3:0]           in_tvalid;
    logic [3:0]           in_tready;
    logic [3:0]           in_tlast;
    logic                 out_hdr_valid;
    logic                 out_hdr_ready;
    ip_hdr_t              out_hdr;
    logic [7:0]           out_tdata;
    logic                 out_tvalid;
    logic                 out_tready;
    logic                 out_tlast;
    logic [1:0]           grant_id;
    logic                 busy;
    logic                 timeout_abort;

    int n_err = 0;
    int n_chk = 0;
    int g_ids[8];
    int g_cyc[8];
    int g_n;
    int g_bad2;
    int k;
    int nrx;
    int n_leak;
    int n;
    logic       xfer;
    logic [7:0] rx[16];
    logic [7:0] pay[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    int         exp_rr[6] = '{0, 1, 3, 0, 1, 3};

    ip_tx_header_arbiter #(
        .N_SRC          (4),
        .DATA_W         (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_hdr_valid  (in_hdr_valid),
        .in_hdr_ready  (in_hdr_ready),
        .in_hdr        (in_hdr),
        .in_tdata      (in_tdata),
        .in_tvalid     (in_tvalid),
        .in_tready     (in_tready),
        .in_tlast      (in_tlast),
        .out_hdr_valid (out_hdr_valid),
        .out_hdr_ready (out_hdr_ready),
        .out_hdr       (out_hdr),
        .out_tdata     (out_tdata),
        .out_tvalid    (out_tvalid),
        .out_tready    (out_tready),
        .out_tlast     (out_tlast),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout_abort (timeout_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ip_hdr_t mk_hdr(input logic [31:0] dst, input logic [7:0] tag);
        ip_hdr_t h;
        h          = '0;
        h.eth_type = 16'h0800;
        h.version  = 4'd4;
        h.ihl      = 4'd5;
        h.ttl      = 8'd64;
        h.protocol = 8'd17;
        h.source_ip = {24'h0A0000, tag};
        h.dest_ip  = dst;
        return h;
    endfunction

    // Header handshake for a lone requester; leaves the DUT at the start of PAYLOAD.
    task automatic open_pkt(input int src, input logic [31:0] dst);
        in_hdr[src]  = mk_hdr(dst, 8'(src));
        in_hdr_valid = 4'(1 << src);
        #1;
        chk("open_hdr_ready", in_hdr_ready, 4'(1 << src));
        tick();
        in_hdr_valid = '0;
        #1;
        chk("open_hdr_valid", out_hdr_valid, 1);
        chk("open_grant_id", grant_id, src);
        chk("open_dest_ip", out_hdr.dest_ip, dst);
        out_hdr_ready = 1'b1;
        tick();
        out_hdr_ready = 1'b0;
    endtask

    // Single-beat packets from every source in mask; records each header grant.
    task automatic run_rr(input logic [3:0] mask, input int ncyc);
        in_hdr_valid  = mask;
        in_tvalid     = 4'hF;
        in_tlast      = 4'hF;
        out_hdr_ready = 1'b1;
        out_tready    = 1'b1;
        g_n           = 0;
        g_bad2        = 0;
        for (int c = 0; c < ncyc; c++) begin
            #1;
            if (in_hdr_ready != 4'b0 && g_n < 8) begin
                for (int i = 0; i < 4; i++) begin
                    if (in_hdr_ready[i]) g_ids[g_n] = i;
                end
                g_cyc[g_n] = c;
                g_n++;
            end
            if (in_hdr_ready[2] || in_tready[2]) g_bad2++;
            tick();
        end
        in_hdr_valid = '0;
        repeat (3) tick();
        in_tvalid     = '0;
        in_tlast      = '0;
        out_hdr_ready = 1'b0;
        out_tready    = 1'b0;
        #1;
        chk("rr_idle_after", busy, 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        in_hdr_valid  = '0;
        in_hdr        = '0;
        in_tdata      = '0;
        in_tvalid     = '0;
        in_tlast      = '0;
        out_hdr_ready = 1'b0;
        out_tready    = 1'b0;
        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_hdr_valid", out_hdr_valid, 0);
        chk("rst_tvalid", out_tvalid, 0);
        chk("rst_hdr_ready", in_hdr_ready, 0);
        chk("rst_tready", in_tready, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_abort", timeout_abort, 0);
        chk("rst_out_hdr", |out_hdr, 0);
        rst_n = 1'b1;
        tick();

        // Single 4-byte packet from source 0
        open_pkt(0, 32'hC0A80102);
        out_tready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            in_tvalid   = 4'b0001;
            in_tdata[0] = pay[b];
            in_tlast[0] = (b == 3);
            #1;
            chk("t1_tvalid", out_tvalid, 1);
            chk("t1_tdata", out_tdata, pay[b]);
            chk("t1_tlast", out_tlast, (b == 3));
            chk("t1_tready", in_tready, 4'b0001);
            tick();
        end
        in_tvalid  = '0;
        in_tlast   = '0;
        out_tready = 1'b0;
        #1;
        chk("t1_busy_fall", busy, 0);

        // Round-robin among sources 0,1,3 from reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        run_rr(4'b1011, 18);
        chk("rr_count", g_n, 6);
        for (int i = 0; i < 6; i++) chk("rr_order", g_ids[i], exp_rr[i]);
        chk("rr_src2_starved", g_bad2, 0);

        // Lone source 0, single-beat packets back to back
        run_rr(4'b0001, 9);
        chk("b2b_count", g_n, 3);
        for (int i = 0; i < 3; i++) begin
            chk("b2b_id", g_ids[i], 0);
            chk("b2b_spacing", g_cyc[i], 3 * i);
        end

        // 8-byte packet from source 1 with out_tready toggling
        open_pkt(1, 32'h0A000001);
        k      = 0;
        nrx    = 0;
        n_leak = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            in_tvalid   = 4'b1111;
            in_tdata[0] = 8'hA0;
            in_tdata[2] = 8'hA2;
            in_tdata[3] = 8'hA3;
            in_tdata[1] = 8'h10 + 8'(k);
            in_tlast    = 4'b1101;
            in_tlast[1] = (k == 7);
            out_tready  = (c % 2 == 0);
            #1;
            if ((in_tready & 4'b1101) != 4'b0) n_leak++;
            if (out_tvalid && out_tready && nrx < 16) begin
                rx[nrx] = out_tdata;
                nrx++;
            end
            xfer = in_tvalid[1] && in_tready[1];
            tick();
            if (xfer) k++;
        end
        in_tvalid  = '0;
        in_tlast   = '0;
        out_tready = 1'b0;
        chk("tog_count", nrx, 8);
        for (int i = 0; i < 8; i++) chk("tog_byte", rx[i], 8'h10 + 8'(i));
        chk("tog_other_tready", n_leak, 0);
        #1;
        chk("tog_idle", busy, 0);

        // Reset in the third payload cycle, then source 2 wins over 3
        open_pkt(1, 32'h0A000002);
        out_tready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            in_tvalid   = 4'b0010;
            in_tdata[1] = 8'h55;
            in_tlast    = '0;
            tick();
        end
        rst_n = 1'b0;
        tick();
        chk("mrst_busy", busy, 0);
        chk("mrst_tvalid", out_tvalid, 0);
        chk("mrst_tready", in_tready, 0);
        chk("mrst_grant_id", grant_id, 0);
        chk("mrst_hdr_valid", out_hdr_valid, 0);
        chk("mrst_out_hdr", |out_hdr, 0);
        rst_n        = 1'b1;
        in_tvalid    = '0;
        in_hdr[2]    = mk_hdr(32'h0A000022, 8'd2);
        in_hdr[3]    = mk_hdr(32'h0A000033, 8'd3);
        in_hdr_valid = 4'b1100;
        #1;
        chk("mrst_pick2", in_hdr_ready, 4'b0100);
        tick();
        in_hdr_valid = '0;
        #1;
        chk("mrst_grant2", grant_id, 2);
        chk("mrst_dest2", out_hdr.dest_ip, 32'h0A000022);
        out_hdr_ready = 1'b1;
        tick();
        out_hdr_ready = 1'b0;
        in_tvalid     = 4'b0100;
        in_tlast      = 4'b0100;
        tick();
        in_tvalid  = '0;
        in_tlast   = '0;
        out_tready = 1'b0;
        #1;
        chk("mrst_done", busy, 0);

`ifdef IP_TX_ARB_TIMEOUT_EN
        // Source 1 stalls after two bytes; forced beat, drain, then source 2
        open_pkt(1, 32'h0A000003);
        out_tready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            in_tvalid   = 4'b0010;
            in_tdata[1] = 8'h60 + 8'(b);
            in_tlast    = '0;
            tick();
        end
        in_tvalid    = '0;
        in_hdr_valid = 4'b0100;
        #1;
        n = 0;
        while (out_tvalid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("to_stall_cycles", n, 16);
        chk("to_forced_tdata", out_tdata, 0);
        chk("to_forced_tlast", out_tlast, 1);
        chk("to_abort_pulse", timeout_abort, 1);
        tick();
        chk("to_abort_clear", timeout_abort, 0);
        chk("to_drain_busy", busy, 1);
        for (int b = 0; b < 3; b++) begin
            in_tvalid   = 4'b0010;
            in_tdata[1] = 8'h70 + 8'(b);
            in_tlast[1] = (b == 2);
            #1;
            chk("to_drain_tready", in_tready, 4'b0010);
            chk("to_drain_tvalid", out_tvalid, 0);
            tick();
        end
        in_tvalid = '0;
        in_tlast  = '0;
        #1;
        chk("to_next_src2", in_hdr_ready, 4'b0100);
        tick();
        in_hdr_valid  = '0;
        out_hdr_ready = 1'b1;
        tick();
        out_hdr_ready = 1'b0;
        in_tvalid     = 4'b0100;
        in_tlast      = 4'b0100;
        tick();
        in_tvalid  = '0;
        in_tlast   = '0;
        out_tready = 1'b0;
        #1;
        chk("to_done", busy, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
